// File: rtl/scrolling_led_driver.sv
// Scrolling seven-segment driver: multiplexes NUM_DIGITS common-anode digits from
// a writable hex message buffer, scrolled by debounced button presses or a timer.
module scrolling_led_driver #(
  parameter int NUM_DIGITS      = 4,
  parameter int MSG_LEN         = 16,
  parameter int REFRESH_DIV     = 16,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int AUTO_PERIOD     = 64,
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn,
  input  logic                  mode,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [3:0]            wr_data,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [AW-1:0]         offset,
  output logic                  btn_stable,
  output logic                  digit_tick
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CW = $clog2(AUTO_PERIOD);

  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] AUTO_MAX  = CW'(AUTO_PERIOD - 1);
  localparam logic [AW:0]   LEN_W     = (AW + 1)'(MSG_LEN);
  localparam logic [AW:0]   SPAN_W    = (AW + 1)'(NUM_DIGITS - 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(MSG_LEN - 1);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [3:0]    buffer [MSG_LEN];
  logic [AW:0]   span;
  logic [AW:0]   sum;
  logic [AW:0]   rd_full;
  logic [AW-1:0] rd_addr;
  logic          sync1;
  logic          sync2;
  logic [DW-1:0] deb_cnt;
  logic          stable_d;
  logic          press;
  logic [CW-1:0] auto_cnt;
  logic          mode_d;
  logic [AW-1:0] next_off;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    hex_to_seg = 7'h7F;
    case (h)
      4'h0: hex_to_seg = 7'h01;
      4'h1: hex_to_seg = 7'h4F;
      4'h2: hex_to_seg = 7'h12;
      4'h3: hex_to_seg = 7'h06;
      4'h4: hex_to_seg = 7'h4C;
      4'h5: hex_to_seg = 7'h24;
      4'h6: hex_to_seg = 7'h20;
      4'h7: hex_to_seg = 7'h0F;
      4'h8: hex_to_seg = 7'h00;
      4'h9: hex_to_seg = 7'h04;
      4'hA: hex_to_seg = 7'h08;
      4'hB: hex_to_seg = 7'h60;
      4'hC: hex_to_seg = 7'h31;
      4'hD: hex_to_seg = 7'h42;
      4'hE: hex_to_seg = 7'h30;
      4'hF: hex_to_seg = 7'h38;
      default: hex_to_seg = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_MAX) begin
      presc <= '0;
      idx   <= (idx == IDX_MAX) ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign digit_tick = (presc == PRESC_MAX);

  // offset + (NUM_DIGITS-1-idx) never exceeds 2*MSG_LEN-2, so one subtract is an exact modulo
  always_comb begin
    span    = SPAN_W - (AW + 1)'(idx);
    sum     = {1'b0, offset} + span;
    rd_full = (sum >= LEN_W) ? sum - LEN_W : sum;
    rd_addr = rd_full[AW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= '1;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= hex_to_seg(buffer[rd_addr]);
      dp  <= (rd_addr != '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        buffer[i] <= '0;
      end
    end else if (wr_en && ({1'b0, wr_addr} < LEN_W)) begin
      buffer[wr_addr] <= wr_data;
    end
  end

  // Any sample agreeing with btn_stable restarts the count, so bounces never accumulate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      deb_cnt    <= '0;
      btn_stable <= 1'b0;
      stable_d   <= 1'b0;
    end else begin
      sync1    <= btn;
      sync2    <= sync1;
      stable_d <= btn_stable;
      if (sync2 != btn_stable) begin
        if (deb_cnt == DEB_LAST) begin
          btn_stable <= sync2;
          deb_cnt    <= '0;
        end else begin
          deb_cnt <= deb_cnt + DW'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign press    = btn_stable & ~stable_d;
  assign next_off = (offset == LAST_ADDR) ? '0 : offset + AW'(1);

  // A press outranks the auto terminal count; a mode flip only restarts the timer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      offset   <= '0;
      auto_cnt <= '0;
      mode_d   <= 1'b0;
    end else begin
      mode_d <= mode;
      if (press) begin
        auto_cnt <= '0;
        offset   <= mode ? '0 : next_off;
      end else if (!mode || (mode != mode_d)) begin
        auto_cnt <= '0;
      end else if (auto_cnt == AUTO_MAX) begin
        auto_cnt <= '0;
        offset   <= next_off;
      end else begin
        auto_cnt <= auto_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_scrolling_led_driver.sv
// Directed bench for scrolling_led_driver: a 4-digit/16-nibble instance and a
// 6-digit/10-nibble instance driven from one clock.
module tb_scrolling_led_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, btn, mode, wr_en;
  logic [3:0] wr_addr, wr_data;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, btn_stable, digit_tick;
  logic [3:0] offset;

  logic       resetb, btnb, modeb, wr_enb;
  logic [3:0] wr_addrb, wr_datab;
  logic [5:0] anb;
  logic [6:0] segb;
  logic       dpb, btn_stableb, digit_tickb;
  logic [3:0] offsetb;

  int errors = 0;
  int checks = 0;
  int cyc, cycb, moff;
  logic [3:0] mdl [16];
  logic [3:0] mb [10];

  scrolling_led_driver #(
    .NUM_DIGITS(4), .MSG_LEN(16), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(8), .AUTO_PERIOD(8)
  ) dut_a (
    .clk(clk), .reset(reset), .btn(btn), .mode(mode), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .an(an), .seg(seg), .dp(dp),
    .offset(offset), .btn_stable(btn_stable), .digit_tick(digit_tick)
  );

  scrolling_led_driver #(
    .NUM_DIGITS(6), .MSG_LEN(10), .REFRESH_DIV(4), .DEBOUNCE_CYCLES(2), .AUTO_PERIOD(4)
  ) dut_b (
    .clk(clk), .reset(resetb), .btn(btnb), .mode(modeb), .wr_en(wr_enb),
    .wr_addr(wr_addrb), .wr_data(wr_datab), .an(anb), .seg(segb), .dp(dpb),
    .offset(offsetb), .btn_stable(btn_stableb), .digit_tick(digit_tickb)
  );

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    logic [6:0] r;
    case (h)
      4'h0: r = 7'h01; 4'h1: r = 7'h4F; 4'h2: r = 7'h12; 4'h3: r = 7'h06;
      4'h4: r = 7'h4C; 4'h5: r = 7'h24; 4'h6: r = 7'h20; 4'h7: r = 7'h0F;
      4'h8: r = 7'h00; 4'h9: r = 7'h04; 4'hA: r = 7'h08; 4'hB: r = 7'h60;
      4'hC: r = 7'h31; 4'hD: r = 7'h42; 4'hE: r = 7'h30; default: r = 7'h38;
    endcase
    return r;
  endfunction

  task tick;
    @(posedge clk);
    #1;
    cyc++;
    cycb++;
  endtask

  task test_reset;
    reset = 1'b0; resetb = 1'b0;
    btn = 0; mode = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
    btnb = 0; modeb = 0; wr_enb = 0; wr_addrb = 0; wr_datab = 0;
    moff = 0;
    for (int i = 0; i < 16; i++) mdl[i] = 4'h0;
    for (int i = 0; i < 10; i++) mb[i] = 4'h0;
    repeat (5) tick;
    checks++; if (an !== 4'b1111) begin errors++; $display("[TB] FAIL reset_an: got %b expected 1111", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("[TB] FAIL reset_seg: got %h expected 7f", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp: got %b expected 1", dp); end
    checks++; if (offset !== 4'd0) begin errors++; $display("[TB] FAIL reset_offset: got %0d expected 0", offset); end
    checks++; if (btn_stable !== 1'b0) begin errors++; $display("[TB] FAIL reset_btn_stable: got %b expected 0", btn_stable); end
    checks++; if (digit_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_digit_tick: got %b expected 0", digit_tick); end
    checks++; if (anb !== 6'h3F) begin errors++; $display("[TB] FAIL reset_anb: got %b expected 111111", anb); end
    reset = 1'b1; resetb = 1'b1;
    cyc = 0; cycb = 0;
  endtask

  task test_scan;
    int d;
    logic [3:0] ea;
    logic et;
    for (int k = 0; k < 20; k++) begin
      tick;
      d  = ((cyc - 1) / 4) % 4;
      ea = ~(4'b0001 << d);
      et = ((cyc % 4) == 3);
      checks++; if (an !== ea) begin errors++; $display("[TB] FAIL scan_an cyc=%0d: got %b expected %b", cyc, an, ea); end
      checks++; if (digit_tick !== et) begin errors++; $display("[TB] FAIL scan_tick cyc=%0d: got %b expected %b", cyc, digit_tick, et); end
    end
  endtask

  task test_display;
    int d, a;
    logic [3:0] ea;
    logic [6:0] es;
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_addr = (i == 4) ? 4'd15 : 4'(i);
      wr_data = (i == 4) ? 4'hE : 4'(i + 1);
      mdl[wr_addr] = wr_data;
      tick;
    end
    wr_en = 1'b0;
    tick; tick;
    for (int k = 0; k < 16; k++) begin
      tick;
      d  = ((cyc - 1) / 4) % 4;
      a  = (moff + 3 - d) % 16;
      ea = ~(4'b0001 << d);
      es = hexseg(mdl[a]);
      checks++; if (an !== ea) begin errors++; $display("[TB] FAIL disp_an cyc=%0d: got %b expected %b", cyc, an, ea); end
      checks++; if (seg !== es) begin errors++; $display("[TB] FAIL disp_seg cyc=%0d: got %h expected %h", cyc, seg, es); end
      checks++; if (dp !== (a != 0)) begin errors++; $display("[TB] FAIL disp_dp cyc=%0d: got %b expected %b", cyc, dp, (a != 0)); end
    end
    // Overwrite the entry the leftmost digit is showing and watch it land on seg
    for (int t = 0; t < 16 && (cyc % 16) != 13; t++) tick;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 4'h5;
    tick;
    wr_en = 1'b0;
    checks++; if (seg !== 7'h4F) begin errors++; $display("[TB] FAIL write_old_seg: got %h expected 4f", seg); end
    tick;
    checks++; if (seg !== 7'h24) begin errors++; $display("[TB] FAIL write_new_seg: got %h expected 24", seg); end
    mdl[0] = 4'h5;
  endtask

  task test_debounce;
    for (int b = 0; b < 3; b++) begin
      btn = 1'b1;
      repeat (3) begin
        tick;
        checks++; if (btn_stable !== 1'b0) begin errors++; $display("[TB] FAIL bounce_hi: got %b expected 0", btn_stable); end
      end
      btn = 1'b0;
      repeat (3) begin
        tick;
        checks++; if (btn_stable !== 1'b0) begin errors++; $display("[TB] FAIL bounce_lo: got %b expected 0", btn_stable); end
      end
    end
    btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick;
      if (k == 9) begin
        checks++; if (btn_stable !== 1'b0) begin errors++; $display("[TB] FAIL deb_early: got %b expected 0", btn_stable); end
      end
      if (k == 10) begin
        checks++; if (btn_stable !== 1'b1) begin errors++; $display("[TB] FAIL deb_rise: got %b expected 1", btn_stable); end
        checks++; if (offset !== 4'd0) begin errors++; $display("[TB] FAIL deb_off_before: got %0d expected 0", offset); end
      end
      if (k == 11) begin
        checks++; if (offset !== 4'd1) begin errors++; $display("[TB] FAIL deb_off_after: got %0d expected 1", offset); end
      end
    end
    btn = 1'b0;
    repeat (12) tick;
    checks++; if (btn_stable !== 1'b0) begin errors++; $display("[TB] FAIL deb_release: got %b expected 0", btn_stable); end
    checks++; if (offset !== 4'd1) begin errors++; $display("[TB] FAIL deb_release_off: got %0d expected 1", offset); end
    moff = 1;
  endtask

  task test_wrap;
    int d, a;
    logic [6:0] es;
    for (int p = 0; p < 16; p++) begin
      btn = 1'b1;
      repeat (12) tick;
      btn = 1'b0;
      repeat (12) tick;
      moff = (moff + 1) % 16;
      checks++; if (offset !== 4'(moff)) begin errors++; $display("[TB] FAIL wrap_offset press=%0d: got %0d expected %0d", p, offset, moff); end
      if (moff == 15) begin
        for (int k = 0; k < 16; k++) begin
          tick;
          d  = ((cyc - 1) / 4) % 4;
          a  = (moff + 3 - d) % 16;
          es = hexseg(mdl[a]);
          checks++; if (seg !== es) begin errors++; $display("[TB] FAIL wrap_seg d=%0d: got %h expected %h", d, seg, es); end
          checks++; if (dp !== (a != 0)) begin errors++; $display("[TB] FAIL wrap_dp d=%0d: got %b expected %b", d, dp, (a != 0)); end
        end
      end
    end
  endtask

  task test_auto;
    int eo;
    mode = 1'b1;
    for (int m = 1; m <= 34; m++) begin
      tick;
      if (m == 14) btn = 1'b1;
      eo = -1;
      case (m)
        8:  eo = moff;
        9:  eo = (moff + 1) % 16;
        16: eo = (moff + 1) % 16;
        17: eo = (moff + 2) % 16;
        24: eo = (moff + 2) % 16;
        25: eo = 0;
        32: eo = 0;
        33: eo = 1;
        default: eo = -1;
      endcase
      if (eo >= 0) begin
        checks++; if (offset !== 4'(eo)) begin errors++; $display("[TB] FAIL auto_offset m=%0d: got %0d expected %0d", m, offset, eo); end
      end
    end
    btn = 1'b0; mode = 1'b0;
    repeat (14) tick;
    checks++; if (offset !== 4'd1) begin errors++; $display("[TB] FAIL auto_mode_exit: got %0d expected 1", offset); end
    moff = 1;
  endtask

  task test_small_config;
    int d, a;
    logic [5:0] ea;
    logic [6:0] es;
    wr_enb = 1'b1; wr_addrb = 4'd5; wr_datab = 4'h9;
    tick;
    mb[5] = 4'h9;
    wr_addrb = 4'd12; wr_datab = 4'h7;
    tick;
    wr_enb = 1'b0;
    tick; tick;
    for (int k = 0; k < 24; k++) begin
      tick;
      d  = ((cycb - 1) / 4) % 6;
      a  = (5 - d) % 10;
      ea = ~(6'b000001 << d);
      es = hexseg(mb[a]);
      checks++; if (anb !== ea) begin errors++; $display("[TB] FAIL b_an cyc=%0d: got %b expected %b", cycb, anb, ea); end
      checks++; if (segb !== es) begin errors++; $display("[TB] FAIL b_seg cyc=%0d: got %h expected %h", cycb, segb, es); end
      checks++; if (dpb !== (a != 0)) begin errors++; $display("[TB] FAIL b_dp cyc=%0d: got %b expected %b", cycb, dpb, (a != 0)); end
    end
    modeb = 1'b1;
    for (int m = 1; m <= 70; m++) begin
      tick;
      if (m == 28) begin checks++; if (offsetb !== 4'd6) begin errors++; $display("[TB] FAIL b_off28: got %0d expected 6", offsetb); end end
      if (m == 29) begin checks++; if (offsetb !== 4'd7) begin errors++; $display("[TB] FAIL b_off29: got %0d expected 7", offsetb); end end
      if (m == 40) begin checks++; if (offsetb !== 4'd9) begin errors++; $display("[TB] FAIL b_off40: got %0d expected 9", offsetb); end end
      if (m == 41) begin checks++; if (offsetb !== 4'd0) begin errors++; $display("[TB] FAIL b_wrap: got %0d expected 0", offsetb); end end
      if (m == 70) begin checks++; if (offsetb !== 4'd7) begin errors++; $display("[TB] FAIL b_off70: got %0d expected 7", offsetb); end end
    end
    // Reset lands mid-scroll and mid-write, between clock edges
    wr_enb = 1'b1; wr_addrb = 4'd3; wr_datab = 4'hF;
    resetb = 1'b0;
    #1;
    checks++; if (anb !== 6'h3F) begin errors++; $display("[TB] FAIL b_rst_an: got %b expected 111111", anb); end
    checks++; if (segb !== 7'h7F) begin errors++; $display("[TB] FAIL b_rst_seg: got %h expected 7f", segb); end
    checks++; if (dpb !== 1'b1) begin errors++; $display("[TB] FAIL b_rst_dp: got %b expected 1", dpb); end
    checks++; if (offsetb !== 4'd0) begin errors++; $display("[TB] FAIL b_rst_offset: got %0d expected 0", offsetb); end
    checks++; if (digit_tickb !== 1'b0) begin errors++; $display("[TB] FAIL b_rst_tick: got %b expected 0", digit_tickb); end
    tick; tick;
    checks++; if (offsetb !== 4'd0) begin errors++; $display("[TB] FAIL b_rst_hold: got %0d expected 0", offsetb); end
    wr_enb = 1'b0; modeb = 1'b0;
    tick;
    resetb = 1'b1;
    cycb = 0;
    for (int i = 0; i < 10; i++) mb[i] = 4'h0;
    for (int k = 0; k < 24; k++) begin
      tick;
      d  = ((cycb - 1) / 4) % 6;
      a  = (5 - d) % 10;
      es = hexseg(mb[a]);
      checks++; if (segb !== es) begin errors++; $display("[TB] FAIL b_clear_seg cyc=%0d: got %h expected %h", cycb, segb, es); end
      checks++; if (dpb !== (a != 0)) begin errors++; $display("[TB] FAIL b_clear_dp cyc=%0d: got %b expected %b", cycb, dpb, (a != 0)); end
    end
    checks++; if (offsetb !== 4'd0) begin errors++; $display("[TB] FAIL b_clear_offset: got %0d expected 0", offsetb); end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_display;
    test_debounce;
    test_wrap;
    test_auto;
    test_small_config;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
